// File: rtl/voice_allocator.sv
// Scheduler that hands note commands to three note_player voices. Notes go to the
// lowest free voice, and advance commands block the command stream for N beats.
module voice_allocator #(
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  play,
  input  logic                  flush,
  input  logic                  beat,
  input  logic                  cmd_valid,
  input  logic                  cmd_is_adv,
  input  logic [NOTE_W-1:0]     cmd_note,
  input  logic [DUR_W-1:0]      cmd_value,
  output logic                  cmd_ready,
  input  logic [2:0]            voice_done,
  output logic [2:0]            voice_load,
  output logic [3*NOTE_W-1:0]   voice_note,
  output logic [3*DUR_W-1:0]    voice_dur,
  output logic [2:0]            busy_mask,
  output logic                  idle
);

  typedef enum logic {
    ACCEPT   = 1'b0,
    WAIT_ADV = 1'b1
  } state_t;

  state_t             state_reg, state_next;
  logic [2:0]         busy_reg, busy_next;
  logic [DUR_W-1:0]   adv_cnt_reg, adv_cnt_next;
  logic [2:0]         voice_load_reg;

  logic [2:0]         free_vec;
  logic [2:0]         lower_free;
  logic [2:0]         sel_vec;
  logic [2:0]         load_vec;
  logic               accept;
  logic               is_note;

  logic [NOTE_W-1:0]  note_reg [3];
  logic [DUR_W-1:0]   dur_reg  [3];

  // Only the registered ownership counts: a voice finishing this cycle
  // becomes allocatable one cycle later.
  assign free_vec = ~busy_reg;
  assign is_note  = (cmd_note != '0);

  // The ready term looks at the payload so rests and advances are never
  // stalled by a full set of voices.
  assign cmd_ready = reset & play & ~flush & (state_reg == ACCEPT) &
                     (cmd_is_adv | ~is_note | (free_vec != 3'b000));
  assign accept    = cmd_valid & cmd_ready;

  // Lowest-index free voice as a one-hot select.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sel
      if (gi == 0) begin : g_first
        assign lower_free[gi] = 1'b0;
      end else begin : g_rest
        assign lower_free[gi] = lower_free[gi-1] | free_vec[gi-1];
      end
      assign sel_vec[gi] = free_vec[gi] & ~lower_free[gi];
    end
  endgenerate

  assign load_vec = {3{accept & ~cmd_is_adv & is_note}} & sel_vec;

  always_comb begin
    state_next   = state_reg;
    adv_cnt_next = adv_cnt_reg;
    busy_next    = (busy_reg & ~voice_done) | load_vec;
    if (flush) begin
      state_next   = ACCEPT;
      adv_cnt_next = '0;
      busy_next    = 3'b000;
    end else begin
      case (state_reg)
        ACCEPT: begin
          if (accept && cmd_is_adv && (cmd_value != '0)) begin
            state_next   = WAIT_ADV;
            adv_cnt_next = cmd_value;
          end
        end
        WAIT_ADV: begin
          if (adv_cnt_reg == '0) begin
            state_next = ACCEPT;
          end else if (beat && play) begin
            adv_cnt_next = adv_cnt_reg - DUR_W'(1);
            if (adv_cnt_reg == DUR_W'(1)) begin
              state_next = ACCEPT;
            end
          end
        end
        default: begin
          state_next   = ACCEPT;
          adv_cnt_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= ACCEPT;
      busy_reg       <= 3'b000;
      adv_cnt_reg    <= '0;
      voice_load_reg <= 3'b000;
    end else begin
      state_reg      <= state_next;
      busy_reg       <= busy_next;
      adv_cnt_reg    <= adv_cnt_next;
      voice_load_reg <= load_vec;
    end
  end

  // Per-voice slots hold the last loaded note until that voice is reloaded.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (!reset) begin
          note_reg[gi] <= '0;
          dur_reg[gi]  <= '0;
        end else if (load_vec[gi]) begin
          note_reg[gi] <= cmd_note;
          dur_reg[gi]  <= cmd_value;
        end
      end
      assign voice_note[gi*NOTE_W +: NOTE_W] = note_reg[gi];
      assign voice_dur[gi*DUR_W +: DUR_W]    = dur_reg[gi];
    end
  endgenerate

  assign voice_load = voice_load_reg;
  assign busy_mask  = busy_reg;
  assign idle       = (state_reg == ACCEPT) && (busy_reg == 3'b000);

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: hand-computed vectors for allocation,
// stalls, advances, rests, flush, same-edge done/load and mid-run reset.
module tb_voice_allocator;

  localparam int NOTE_W = 6;
  localparam int DUR_W  = 6;

  logic                clk = 1'b0;
  logic                reset;
  logic                play;
  logic                flush;
  logic                beat;
  logic                cmd_valid;
  logic                cmd_is_adv;
  logic [NOTE_W-1:0]   cmd_note;
  logic [DUR_W-1:0]    cmd_value;
  logic                cmd_ready;
  logic [2:0]          voice_done;
  logic [2:0]          voice_load;
  logic [3*NOTE_W-1:0] voice_note;
  logic [3*DUR_W-1:0]  voice_dur;
  logic [2:0]          busy_mask;
  logic                idle;

  int vec_count = 0;
  int miscompares = 0;

  voice_allocator #(.NOTE_W(NOTE_W), .DUR_W(DUR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .play       (play),
    .flush      (flush),
    .beat       (beat),
    .cmd_valid  (cmd_valid),
    .cmd_is_adv (cmd_is_adv),
    .cmd_note   (cmd_note),
    .cmd_value  (cmd_value),
    .cmd_ready  (cmd_ready),
    .voice_done (voice_done),
    .voice_load (voice_load),
    .voice_note (voice_note),
    .voice_dur  (voice_dur),
    .busy_mask  (busy_mask),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic v, input logic adv, input int note, input int val);
    cmd_valid  = v;
    cmd_is_adv = adv;
    cmd_note   = NOTE_W'(note);
    cmd_value  = DUR_W'(val);
  endtask

  initial begin
    reset = 1'b0; play = 1'b1; flush = 1'b0; beat = 1'b0;
    voice_done = 3'b000;
    set_cmd(1'b1, 1'b0, 10, 4);

    // Reset held two edges, with a note already presented.
    tick();
    chk("rst_idle", 32'(idle), 32'd1);
    tick();
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    chk("rst_busy", 32'(busy_mask), 32'd0);
    chk("rst_load", 32'(voice_load), 32'd0);
    chk("rst_note", 32'(voice_note), 32'd0);
    chk("rst_dur", 32'(voice_dur), 32'd0);

    // Three notes on consecutive cycles fill voices 0,1,2.
    reset = 1'b1;
    #1 chk("n10_ready", 32'(cmd_ready), 32'd1);
    tick();
    chk("n10_load", 32'(voice_load), 32'b001);
    chk("n10_busy", 32'(busy_mask), 32'b001);
    set_cmd(1'b1, 1'b0, 14, 4);
    tick();
    chk("n14_load", 32'(voice_load), 32'b010);
    set_cmd(1'b1, 1'b0, 17, 4);
    tick();
    chk("n17_load", 32'(voice_load), 32'b100);
    chk("n17_busy", 32'(busy_mask), 32'b111);
    chk("n17_notes", 32'(voice_note), 32'({6'd17, 6'd14, 6'd10}));
    chk("n17_durs", 32'(voice_dur), 32'({6'd4, 6'd4, 6'd4}));

    // Fourth note stalls until a voice frees up.
    set_cmd(1'b1, 1'b0, 22, 7);
    #1 chk("n22_stall", 32'(cmd_ready), 32'd0);
    tick();
    chk("n22_noload", 32'(voice_load), 32'b000);
    voice_done = 3'b010;
    #1 chk("n22_ready_at_done", 32'(cmd_ready), 32'd0);
    tick();
    voice_done = 3'b000;
    chk("n22_busy101", 32'(busy_mask), 32'b101);
    chk("n22_noload2", 32'(voice_load), 32'b000);
    #1 chk("n22_ready", 32'(cmd_ready), 32'd1);
    tick();
    chk("n22_load", 32'(voice_load), 32'b010);
    chk("n22_notes", 32'(voice_note), 32'({6'd17, 6'd22, 6'd10}));
    chk("n22_durs", 32'(voice_dur), 32'({6'd4, 6'd7, 6'd4}));
    chk("n22_busy", 32'(busy_mask), 32'b111);

    // Release everything.
    set_cmd(1'b0, 1'b0, 0, 0);
    voice_done = 3'b111;
    tick();
    voice_done = 3'b000;
    chk("clr_busy", 32'(busy_mask), 32'b000);
    chk("clr_idle", 32'(idle), 32'd1);

    // Advance 3: beats at 4, 9 (play low), 12, 15 -> ready from cycle 16.
    set_cmd(1'b1, 1'b1, 0, 3);
    tick();
    chk("adv3_idle", 32'(idle), 32'd0);
    set_cmd(1'b1, 1'b0, 5, 2);
    for (int k = 1; k <= 16; k++) begin
      beat = (k == 4 || k == 9 || k == 12 || k == 15);
      play = (k != 9);
      #1 chk($sformatf("adv3_ready_c%0d", k), 32'(cmd_ready), 32'(k >= 16));
      tick();
    end
    beat = 1'b0; play = 1'b1;
    chk("n5_load", 32'(voice_load), 32'b001);
    chk("n5_busy", 32'(busy_mask), 32'b001);

    // Rest, then advance 0: consumed without loads or state change.
    set_cmd(1'b1, 1'b0, 0, 9);
    #1 chk("rest_ready", 32'(cmd_ready), 32'd1);
    tick();
    chk("rest_load", 32'(voice_load), 32'b000);
    chk("rest_busy", 32'(busy_mask), 32'b001);
    set_cmd(1'b1, 1'b1, 0, 0);
    #1 chk("adv0_ready", 32'(cmd_ready), 32'd1);
    tick();
    chk("adv0_load", 32'(voice_load), 32'b000);
    chk("adv0_busy", 32'(busy_mask), 32'b001);
    #1 chk("adv0_still_accept", 32'(cmd_ready), 32'd1);

    // Fill voices, enter WAIT_ADV with 5, then flush.
    set_cmd(1'b1, 1'b0, 30, 1);
    tick();
    set_cmd(1'b1, 1'b0, 31, 2);
    tick();
    set_cmd(1'b1, 1'b1, 0, 5);
    tick();
    chk("fl_busy_pre", 32'(busy_mask), 32'b111);
    set_cmd(1'b0, 1'b0, 0, 0);
    flush = 1'b1;
    #1 chk("fl_ready_during", 32'(cmd_ready), 32'd0);
    tick();
    flush = 1'b0;
    chk("fl_busy", 32'(busy_mask), 32'b000);
    chk("fl_idle", 32'(idle), 32'd1);
    chk("fl_notes", 32'(voice_note), 32'({6'd31, 6'd30, 6'd5}));
    set_cmd(1'b1, 1'b0, 40, 3);
    #1 chk("fl_ready", 32'(cmd_ready), 32'd1);
    tick();
    chk("n40_load", 32'(voice_load), 32'b001);

    // busy=011, done on voice 0 with a new note in the same edge.
    set_cmd(1'b1, 1'b0, 41, 3);
    tick();
    chk("se_busy_pre", 32'(busy_mask), 32'b011);
    set_cmd(1'b1, 1'b0, 42, 6);
    voice_done = 3'b001;
    tick();
    voice_done = 3'b000;
    set_cmd(1'b0, 1'b0, 0, 0);
    chk("se_load", 32'(voice_load), 32'b100);
    chk("se_busy", 32'(busy_mask), 32'b110);
    chk("se_notes", 32'(voice_note), 32'({6'd42, 6'd41, 6'd40}));

    // Reset in the middle of an advance.
    set_cmd(1'b1, 1'b1, 0, 4);
    tick();
    set_cmd(1'b1, 1'b0, 50, 1);
    #1 chk("mr_wait_ready", 32'(cmd_ready), 32'd0);
    reset = 1'b0;
    tick();
    chk("mr_busy", 32'(busy_mask), 32'd0);
    chk("mr_load", 32'(voice_load), 32'd0);
    chk("mr_note", 32'(voice_note), 32'd0);
    chk("mr_dur", 32'(voice_dur), 32'd0);
    chk("mr_idle", 32'(idle), 32'd1);
    chk("mr_ready_low", 32'(cmd_ready), 32'd0);
    reset = 1'b1;
    #1 chk("mr_ready", 32'(cmd_ready), 32'd1);
    tick();
    chk("mr_n50_load", 32'(voice_load), 32'b001);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Scheduler between the song reader and the three note_player voices of the chord player. It accepts a single stream of note and advance commands over a valid/ready handshake. Each note goes to the lowest-index free voice, and busy state is tracked per voice from the players' done pulses. Advance commands hold off further commands for a programmed number of beats, which is how notes are grouped into chords.

## Interface
- NOTE_W, 6, width of note field (0 = rest)
- DUR_W, 6, width of duration / advance field in beats
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-low; reset==0 at an edge resets the block
- play  in  1  run enable; low pauses acceptance and advance counting
- flush  in  1  rewind/ff request; one-cycle pulse, drops all voice ownership and any pending advance
- beat  in  1  one-cycle beat strobe
- cmd_valid  in  1  command present
- cmd_is_adv  in  1  1 = advance command, 0 = note command
- cmd_note  in  NOTE_W  note number (ignored for advance)
- cmd_value  in  DUR_W  note duration, or advance length in beats
- cmd_ready  out  1  command accepted at this edge when cmd_valid & cmd_ready
- voice_done  in  3  done_with_note pulses from note_player 0..2
- voice_load  out  3  one-cycle load_new_note pulse per voice
- voice_note  out  3*NOTE_W  per-voice note, voice i at bits [i*NOTE_W +: NOTE_W]
- voice_dur  out  3*DUR_W  per-voice duration, same packing
- busy_mask  out  3  registered voice ownership
- idle  out  1  state==ACCEPT and busy_mask==0

## Operation
- States:
  - ACCEPT: take commands.
  - WAIT_ADV: count beats.
- free = ~busy_mask, registered value only. A voice whose done pulse arrives this cycle is not allocatable until the next cycle.
- cmd_ready = play & ~flush & state==ACCEPT & (cmd_is_adv | cmd_note==0 | free!=0).
  - cmd_ready depends on the command payload. This is intentional.
- Accepted note, cmd_note!=0:
  - Target is the lowest-index voice with free bit set.
  - Register the note and duration into that voice's voice_note/voice_dur slot.
  - Pulse that voice's voice_load.
  - Set its busy bit.
- Accepted rest, cmd_note==0: consumed, no load, no state change.
- Accepted advance:
  - cmd_value==0: no-op, stay in ACCEPT.
  - Otherwise load adv_cnt=cmd_value and go to WAIT_ADV.
- WAIT_ADV:
  - On beat & play: adv_cnt decrements.
  - When a decrement takes adv_cnt from 1 to 0, return to ACCEPT at that edge.
  - cmd_ready is 0 throughout.
- voice_done[i] clears busy_mask[i] at the next edge, regardless of play or state.
  - A done pulse on a voice that is not busy is ignored.
- Same-edge events on different voices (load on j, done on i) both take effect.
- flush at an edge:
  - busy_mask<=0, state<=ACCEPT, adv_cnt<=0.
  - No command is accepted at that edge; voice_load stays 0.
  - voice_note/voice_dur keep their values.
- play low: nothing is accepted and beats do not decrement adv_cnt. Done pulses still clear busy bits.
- voice_note/voice_dur hold their last loaded value until the next load to that voice.

## Timing
- Reset (reset==0 at an edge), applied mid-operation as well:
  - state=ACCEPT, busy_mask=0, adv_cnt=0.
  - voice_load=0, voice_note=0, voice_dur=0.
  - cmd_ready=0 while reset is low; idle=1 from the first edge after reset.
- Accept at edge N: voice_load, voice_note, voice_dur and busy_mask are all valid after edge N, for cycle N+1.
  - voice_load is high for exactly that one cycle.
- At most one command is accepted per cycle, so back-to-back notes load voices 0, 1, 2 on consecutive cycles.
- Advance of K beats accepted at edge N: cmd_ready rises again in the cycle after the edge sampling the K-th qualifying beat.
- Done pulse at edge M: busy bit is cleared after M. A stalled note is accepted at edge M+1 at the earliest.
- adv_cnt is DUR_W bits wide and never wraps: no decrement at 0, no decrement outside WAIT_ADV.

## Test plan
- Reset held low 2 cycles, then released, play=1:
  - Commands note 10/dur 4, note 14/dur 4, note 17/dur 4 on consecutive cycles.
  - Required: voice_load = 001, 010, 100 on successive cycles; voice_note slots 10, 14, 17; busy_mask=111.
- All voices busy, fourth note 22 valid:
  - Required: cmd_ready=0.
  - Pulse voice_done=010 → busy_mask=101 next cycle; note 22 loads voice 1 the following edge; voice_load=010.
- Advance of 3 beats accepted, then note 5 valid:
  - Beats at cycles 4, 9, 12; play dropped during cycle 9, so that beat does not count.
  - Required: cmd_ready stays low until after the beat at cycle 12 plus one more qualifying beat; no early accept.
- Rest (note 0) and advance 0:
  - Each accepted in one cycle, no voice_load, busy_mask unchanged, state stays ACCEPT.
- flush while busy_mask=111 and in WAIT_ADV with adv_cnt=5:
  - Required: next cycle busy_mask=0, idle=1, cmd_ready=1; voice_note values unchanged.
- Same-edge done on voice 0 and load of a new note while busy=011:
  - Required: the new note goes to voice 2 (not 0); busy_mask becomes 110.
- reset driven low mid-WAIT_ADV:
  - Required: all outputs return to their reset values at the next edge.
